// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin packet arbiter sharing the UART transmit FIFO push port among requesters.
// Latency: grant is registered one cycle after a request is seen in IDLE; words then pass through combinationally.
// Backpressure: fifo_full drops the owner's req_ready in the same cycle; full-stalled cycles freeze the watchdog.
//
// Ports:
//   sys_clk, rst_n      - clock and synchronous active-low reset
//   req_valid/last/data - per-requester word offer; requester k data at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready           - word from requester k accepted this cycle (owner only, when FIFO not full)
//   fifo_push/data/full - push interface into the UART controller input FIFO
//   grant, busy         - one-hot current owner, and packet-locked flag
//   timeout_pulse/id    - one-cycle watchdog revoke strobe and the revoked requester index (held)
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          timeout_pulse,
    output logic [$clog2(NUM_REQ)-1:0]    timeout_id
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 tpulse_q, tpulse_d;
    logic [IDW-1:0]       tid_q, tid_d;

    logic                 own_vld;
    logic                 own_last;
    logic [DATA_WIDTH-1:0] own_dat;
    logic                 xfer;
    logic [IDW-1:0]       pick;
    logic [IDW-1:0]       ptr_next;

    // First requesting index at or above p, wrapping past NUM_REQ-1 back to 0.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDW-1:0]     p);
        logic [IDW-1:0] sel;
        logic           found;
        int             idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(p) + i) % NUM_REQ;
            if (!found && v[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
        return sel;
    endfunction

    // Owner's handshake signals, selected by the one-hot grant register.
    always_comb begin
        own_vld  = 1'b0;
        own_last = 1'b0;
        own_dat  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                own_vld  = req_valid[k];
                own_last = req_last[k];
                own_dat  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer     = (state_q == ST_LOCKED) && own_vld && !fifo_full;
    assign pick     = rr_pick(req_valid, ptr_q);
    // Pointer moves one past the owner whenever a grant is released.
    assign ptr_next = (gidx_q == IDW'(NUM_REQ - 1)) ? '0 : gidx_q + IDW'(1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        tpulse_d = 1'b0;
        tid_d    = tid_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d       = ST_LOCKED;
                    gidx_d        = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    cnt_d         = '0;
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    // A transfer always beats the watchdog, even when the count sits at TIMEOUT.
                    cnt_d = '0;
                    if (own_last) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = ptr_next;
                    end
                end else if (cnt_q == 16'(TIMEOUT)) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    ptr_d    = ptr_next;
                    tpulse_d = 1'b1;
                    tid_d    = gidx_q;
                end else if (!own_vld) begin
                    // Only owner starvation counts; a full FIFO holds the count.
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            tpulse_q <= 1'b0;
            tid_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            tpulse_q <= tpulse_d;
            tid_q    <= tid_d;
        end
    end

    assign req_ready     = ((state_q == ST_LOCKED) && !fifo_full) ? grant_q : '0;
    assign fifo_push     = xfer;
    assign fifo_data     = xfer ? own_dat : '0;
    assign grant         = grant_q;
    assign busy          = (state_q == ST_LOCKED);
    assign timeout_pulse = tpulse_q;
    assign timeout_id    = tid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: self-checking bench for uart_tx_arbiter with an ownership-level reference model.
// Latency: model predicts every output each cycle; literal checks pin packet order and timing.
// Backpressure: fifo_full is driven directly by the directed sequences.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int TO      = 8;

    logic                     sys_clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ*DW-1:0]    req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_push;
    logic [DW-1:0]            fifo_data;
    logic                     fifo_full;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic                     timeout_pulse;
    logic [1:0]               timeout_id;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_push    (fifo_push),
        .fifo_data    (fifo_data),
        .fifo_full    (fifo_full),
        .grant        (grant),
        .busy         (busy),
        .timeout_pulse(timeout_pulse),
        .timeout_id   (timeout_id)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester sources: per-requester ring of {last, data}.
    logic [DW:0] src [NUM_REQ][16];
    int hd [NUM_REQ];
    int tl [NUM_REQ];

    task automatic enq(input int k, input logic [DW-1:0] d, input bit last);
        src[k][tl[k] % 16] = {last, d};
        tl[k]++;
    endtask

    task automatic drive();
        logic [DW:0] w;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (hd[k] != tl[k]) begin
                w = src[k][hd[k] % 16];
                req_valid[k] = 1'b1;
                req_last[k]  = w[DW];
                req_data[k*DW +: DW] = w[DW-1:0];
            end else begin
                req_valid[k] = 1'b0;
                req_last[k]  = 1'($urandom_range(0, 1));
                req_data[k*DW +: DW] = $urandom;
            end
        end
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] acc;
        @(negedge sys_clk);
        acc = req_valid & req_ready;
        @(posedge sys_clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) if (acc[k]) hd[k]++;
        drive();
    endtask

    // Observed-event logs, filled by the compare process.
    logic [DW-1:0] push_dat [$];
    int            push_cyc [$];
    int            grant_id [$];
    int            grant_cyc[$];
    int            tp_cyc   [$];
    int            tp_id    [$];
    int            tp_grant [$];
    int            busy_fall_cyc = 0;

    task automatic wait_pushes(input int n, input int budget, input string name);
        int b = 0;
        while (push_dat.size() < n && b < budget) begin
            step();
            b++;
        end
        check(name, 64'(push_dat.size() >= n), 64'd1);
    endtask

    // Reference model: who owns the FIFO, where the search starts next, and how long the owner has starved.
    int m_owner  = -1;
    int m_ptr    = 0;
    int m_starve = 0;
    bit m_tpulse = 1'b0;
    int m_tid    = 0;

    int  nx_owner, nx_ptr, nx_starve, nx_tid;
    bit  nx_tp, nx_found;

    always @(posedge sys_clk) begin
        nx_owner  = m_owner;
        nx_ptr    = m_ptr;
        nx_starve = m_starve;
        nx_tid    = m_tid;
        nx_tp     = 1'b0;
        if (!rst_n) begin
            nx_owner = -1; nx_ptr = 0; nx_starve = 0; nx_tid = 0;
        end else if (nx_owner < 0) begin
            nx_found = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!nx_found && req_valid[(m_ptr + i) % NUM_REQ]) begin
                    nx_found  = 1'b1;
                    nx_owner  = (m_ptr + i) % NUM_REQ;
                    nx_starve = 0;
                end
            end
        end else if (req_valid[m_owner] && !fifo_full) begin
            nx_starve = 0;
            if (req_last[m_owner]) begin
                nx_ptr   = (m_owner + 1) % NUM_REQ;
                nx_owner = -1;
            end
        end else if (m_starve == TO) begin
            nx_tp    = 1'b1;
            nx_tid   = m_owner;
            nx_ptr   = (m_owner + 1) % NUM_REQ;
            nx_owner = -1;
        end else if (!req_valid[m_owner]) begin
            nx_starve = m_starve + 1;
        end
        m_owner  <= nx_owner;
        m_ptr    <= nx_ptr;
        m_starve <= nx_starve;
        m_tid    <= nx_tid;
        m_tpulse <= nx_tp;
    end

    logic [NUM_REQ-1:0] e_grant, e_ready, prev_grant;
    logic               e_push, prev_busy;
    logic [DW-1:0]      e_data;

    always @(negedge sys_clk) begin
        if (chk_en) begin
            e_grant = '0;
            if (m_owner >= 0) e_grant[m_owner] = 1'b1;
            e_ready = (m_owner >= 0 && !fifo_full) ? e_grant : '0;
            e_push  = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
            e_data  = e_push ? req_data[m_owner*DW +: DW] : '0;
            check("grant",         64'(grant),         64'(e_grant));
            check("busy",          64'(busy),          64'(m_owner >= 0));
            check("req_ready",     64'(req_ready),     64'(e_ready));
            check("fifo_push",     64'(fifo_push),     64'(e_push));
            check("fifo_data",     64'(fifo_data),     64'(e_data));
            check("timeout_pulse", 64'(timeout_pulse), 64'(m_tpulse));
            check("timeout_id",    64'(timeout_id),    64'(m_tid));

            if (fifo_push) begin
                push_dat.push_back(fifo_data);
                push_cyc.push_back(cyc);
            end
            if (grant != 0 && prev_grant == 0) begin
                for (int k = 0; k < NUM_REQ; k++) if (grant[k]) grant_id.push_back(k);
                grant_cyc.push_back(cyc);
            end
            if (timeout_pulse) begin
                tp_cyc.push_back(cyc);
                tp_id.push_back(int'(timeout_id));
                tp_grant.push_back(int'(grant));
            end
            if (!busy && prev_busy) busy_fall_cyc = cyc;
        end
        prev_grant = grant;
        prev_busy  = busy;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: bench did not reach its summary");
        $fatal(1, "time limit");
    end

    initial begin
        int pb, gb, tpb, v_cyc;
        for (int k = 0; k < NUM_REQ; k++) begin hd[k] = 0; tl[k] = 0; end
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        drive();
        step();
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;
        check("reset_grant",  64'(grant),     64'd0);
        check("reset_busy",   64'(busy),      64'd0);
        check("reset_ready",  64'(req_ready), 64'd0);
        check("reset_tid",    64'(timeout_id), 64'd0);

        // Round robin from ptr 0: A0..A3 with one bubble between pushes.
        pb = push_dat.size();
        for (int k = 0; k < NUM_REQ; k++) enq(k, 32'hA0 + k, 1'b1);
        step();
        wait_pushes(pb + 4, 40, "rr_wait");
        for (int i = 0; i < 4; i++) check("rr_word", 64'(push_dat[pb+i]), 64'(32'hA0 + i));
        for (int i = 1; i < 4; i++) check("rr_gap", 64'(push_cyc[pb+i] - push_cyc[pb+i-1]), 64'd2);
        pb = push_dat.size();
        gb = grant_id.size();
        enq(0, 32'hB0, 1'b1);
        enq(2, 32'hB2, 1'b1);
        step();
        wait_pushes(pb + 2, 20, "rr2_wait");
        check("rr2_first_owner",  64'(grant_id[gb]),   64'd0);
        check("rr2_second_owner", 64'(grant_id[gb+1]), 64'd2);
        check("rr2_word0", 64'(push_dat[pb]),   64'h0000_00B0);
        check("rr2_word1", 64'(push_dat[pb+1]), 64'h0000_00B2);

        // Single 3-word packet on req 0.
        pb = push_dat.size();
        gb = grant_id.size();
        enq(0, 32'h1111_1111, 1'b0);
        enq(0, 32'h2222_2222, 1'b0);
        enq(0, 32'h3333_3333, 1'b1);
        step();
        v_cyc = cyc;
        wait_pushes(pb + 3, 20, "single_wait");
        step();
        check("single_owner",     64'(grant_id[gb]), 64'd0);
        check("single_grant_lat", 64'(grant_cyc[gb] - v_cyc), 64'd1);
        check("single_push_lat",  64'(push_cyc[pb] - v_cyc), 64'd1);
        check("single_w0", 64'(push_dat[pb]),   64'h1111_1111);
        check("single_w1", 64'(push_dat[pb+1]), 64'h2222_2222);
        check("single_w2", 64'(push_dat[pb+2]), 64'h3333_3333);
        check("single_back2back", 64'(push_cyc[pb+2] - push_cyc[pb]), 64'd2);
        check("single_busy_drop", 64'(busy_fall_cyc - push_cyc[pb+2]), 64'd1);

        // Backpressure: full for 10 cycles (longer than TIMEOUT) mid-packet on req 1.
        pb  = push_dat.size();
        tpb = tp_cyc.size();
        for (int i = 0; i < 4; i++) enq(1, 32'hC0 + i, i == 3);
        step();
        wait_pushes(pb + 2, 20, "bp_wait_a");
        fifo_full = 1'b1;
        repeat (10) step();
        fifo_full = 1'b0;
        wait_pushes(pb + 4, 20, "bp_wait_b");
        for (int i = 0; i < 4; i++) check("bp_word", 64'(push_dat[pb+i]), 64'(32'hC0 + i));
        check("bp_stall_gap",   64'(push_cyc[pb+2] - push_cyc[pb+1]), 64'd11);
        check("bp_no_timeout",  64'(tp_cyc.size() - tpb), 64'd0);

        // Watchdog: req 2 sends one non-last word then goes quiet; req 3 waits.
        pb  = push_dat.size();
        gb  = grant_id.size();
        tpb = tp_cyc.size();
        enq(2, 32'hDEAD_BEEF, 1'b0);
        enq(3, 32'h0303_0303, 1'b1);
        step();
        wait_pushes(pb + 2, 60, "wd_wait");
        step();
        check("wd_word",        64'(push_dat[pb]),   64'hDEAD_BEEF);
        check("wd_next_word",   64'(push_dat[pb+1]), 64'h0303_0303);
        check("wd_pulse_count", 64'(tp_cyc.size() - tpb), 64'd1);
        check("wd_pulse_time",  64'(tp_cyc[tpb] - push_cyc[pb]), 64'(TO + 2));
        check("wd_id",          64'(tp_id[tpb]),    64'd2);
        check("wd_grant_at_pulse", 64'(tp_grant[tpb]), 64'd0);
        check("wd_owner_a",     64'(grant_id[gb]),  64'd2);
        check("wd_owner_b",     64'(grant_id[gb+1]), 64'd3);
        check("wd_regrant_lat", 64'(grant_cyc[gb+1] - tp_cyc[tpb]), 64'd1);
        check("wd_id_held",     64'(timeout_id),    64'd2);

        // Reset mid-packet, with ptr moved to 3 beforehand.
        pb = push_dat.size();
        enq(2, 32'h0000_0F02, 1'b1);
        step();
        wait_pushes(pb + 1, 20, "rst_pre_wait");
        pb = push_dat.size();
        for (int i = 0; i < 4; i++) enq(1, 32'hD0 + i, i == 3);
        step();
        wait_pushes(pb + 2, 20, "rst_half_wait");
        rst_n = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) hd[k] = tl[k];
        drive();
        step();
        rst_n = 1'b1;
        check("rst_grant", 64'(grant),     64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_push",  64'(fifo_push), 64'd0);
        check("rst_tid",   64'(timeout_id), 64'd0);
        gb = grant_id.size();
        enq(3, 32'hE3, 1'b1);
        enq(0, 32'hE0, 1'b1);
        step();
        wait_pushes(pb + 4, 20, "rst_post_wait");
        check("rst_owner_ptr0", 64'(grant_id[gb]), 64'd0);
        check("rst_word_d1",    64'(push_dat[pb+1]), 64'h0000_00D1);
        check("rst_word_e0",    64'(push_dat[pb+2]), 64'h0000_00E0);
        check("rst_word_e3",    64'(push_dat[pb+3]), 64'h0000_00E3);

        // Fairness: req 1 keeps requesting, req 3 joins during its first packet.
        pb = push_dat.size();
        gb = grant_id.size();
        for (int i = 0; i < 6; i++) enq(1, 32'hF10 + i, i % 2 == 1);
        step();
        for (int b = 0; b < 10 && grant_id.size() == gb; b++) step();
        for (int i = 0; i < 4; i++) enq(3, 32'hF30 + i, i % 2 == 1);
        wait_pushes(pb + 10, 80, "fair_wait");
        check("fair_g0", 64'(grant_id[gb]),   64'd1);
        check("fair_g1", 64'(grant_id[gb+1]), 64'd3);
        check("fair_g2", 64'(grant_id[gb+2]), 64'd1);
        check("fair_g3", 64'(grant_id[gb+3]), 64'd3);
        check("fair_g4", 64'(grant_id[gb+4]), 64'd1);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin packet arbiter that shares the UART controller's transmit input FIFO (32-bit word push interface) between several on-chip requesters, such as the move engine, game-state reporter and debug port. It grants one requester at a time and holds the grant for a whole multi-word packet so packets never interleave on the serial link. A watchdog releases a grant whose owner stalls mid-packet. It sits in the sys_clk domain, directly in front of the UART controller's push/data/full port.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, word width; matches the UART controller FIFO width
- TIMEOUT, 255, number of consecutive starved cycles before a locked grant is revoked (1..65535)

Ports:
- sys_clk  in  1  system clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  requester k presents a word
- req_last  in  NUM_REQ  requester k's current word ends its packet
- req_data  in  NUM_REQ*DATA_WIDTH  requester k word at [k*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  word from requester k accepted this cycle when req_valid[k] is also high
- fifo_push  out  1  push strobe to the UART controller input FIFO
- fifo_data  out  DATA_WIDTH  word pushed
- fifo_full  in  1  UART controller input FIFO full
- grant  out  NUM_REQ  one-hot owner of the FIFO, all zero when idle
- busy  out  1  a packet is locked
- timeout_pulse  out  1  one-cycle strobe when a grant is revoked by the watchdog
- timeout_id  out  $clog2(NUM_REQ)  index of the revoked requester, held until the next timeout

## Operation
- State machine: IDLE, LOCKED.
- IDLE: if any req_valid is high, select the first set bit searching upward from ptr with wrap-around. Register grant and go to LOCKED. No word transfers in IDLE.
- LOCKED, owner g:
  - req_ready[g] = ~fifo_full; all other req_ready bits are 0.
  - A transfer occurs when req_valid[g] & ~fifo_full. On a transfer, fifo_push = 1 and fifo_data = req_data[g], combinationally in the same cycle.
  - A transfer with req_last[g] = 1 returns the machine to IDLE and sets ptr = (g+1) mod NUM_REQ.
- Watchdog counter (16 bits):
  - Cleared on entry to LOCKED and on every transfer.
  - Increments only on cycles where req_valid[g] = 0. Cycles stalled by fifo_full do not count and hold the counter.
  - When the counter reaches TIMEOUT, the machine goes to IDLE on the next edge, asserts timeout_pulse for one cycle, loads timeout_id = g, and sets ptr = (g+1) mod NUM_REQ.
  - Words already pushed are not retracted.
- Non-granted requesters are ignored. Their valid/data may change freely.
- A single-word packet has req_last set on its first word.
- fifo_data is 0 when fifo_push = 0.

## Timing
- Reset values (rst_n low at a sys_clk edge): state IDLE, ptr 0, grant 0, busy 0, req_ready 0, fifo_push 0, fifo_data 0, timeout_pulse 0, timeout_id 0, counter 0.
- Grant latency: req_valid sampled high in IDLE at edge N gives grant and busy high after edge N. The first push can occur in that same cycle (N+1).
- Throughput: one word per cycle while locked and fifo_full = 0.
- Packet turnaround: a last-word transfer in cycle M gives IDLE in cycle M+1 and a new grant in cycle M+2. There is exactly one bubble cycle between packets.
- Backpressure: fifo_full is evaluated combinationally in the same cycle. A push is never issued while fifo_full = 1.
- Timeout: with req_valid[g] low from cycle L, timeout_pulse is high in cycle L+TIMEOUT+1 and grant is 0 in that cycle.
- Reset mid-packet: the partial packet is abandoned with no further pushes. Outputs take their reset values in the cycle after the edge where rst_n is sampled low.
- Simultaneous last-word transfer and counter reaching TIMEOUT: the transfer wins and no timeout is flagged. This follows from the transfer clearing the counter.

## Test plan
- Single packet: after reset, req 0 sends 0x11111111, 0x22222222, 0x33333333 (last) with fifo_full = 0 -> grant = 4'b0001 one cycle after valid; three consecutive pushes carrying those words; busy drops the cycle after the last push.
- Round robin: all four requesters hold a valid 1-word packet (data 0xA0..0xA3) -> push order A0, A1, A2, A3, one bubble between each; then req 0 is served again.
- Backpressure: fifo_full high for 10 cycles mid-packet with TIMEOUT = 4 -> no push, req_ready[g] low, no timeout_pulse; the remaining words are pushed intact and in order after fifo_full falls.
- Watchdog: with TIMEOUT = 8, req 2 pushes 0xDEADBEEF (not last) and then drops valid -> timeout_pulse for exactly one cycle, 9 cycles later; timeout_id = 2; grant cleared; a pending req 3 is granted next.
- Reset mid-packet: assert rst_n = 0 for one edge after 2 of 4 words -> all outputs at reset values; the next arbitration starts from ptr 0.
- Fairness: req 1 requests continuously and req 3 raises a request -> grants alternate 1, 3, 1, 3.
